// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite blit reader.
//   ADDR_W / COLOR_W     : ROM address and palette-index widths
//   SCREEN_W / SCREEN_H  : visible area; pixels at or beyond these are dropped
//   TRANSPARENT          : colour index that is never emitted
//   state_e              : reader FSM states
//   pixel_t              : one frame-buffer write {x, y, color}
package sprite_pkg;

    localparam int unsigned ADDR_W   = 19;
    localparam int unsigned COLOR_W  = 5;
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    localparam logic [COLOR_W-1:0] TRANSPARENT = '0;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StDone
    } state_e;

    typedef struct packed {
        logic [9:0]         x;
        logic [8:0]         y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

endpackage

// File: rtl/sprite_blit_reader_fifo.sv
// pix_fifo2: two-entry synchronous FIFO of pixel_t.
//   Clk, Reset_n : clock, synchronous active-low reset (clears pointers/count)
//   push, wdata  : write request and data (ignored when full unless popping)
//   pop          : read request (ignored when empty)
//   rdata        : current head entry (valid when count != 0)
//   count        : number of stored entries, 0..2
module pix_fifo2
    import sprite_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       push,
    input  pixel_t     wdata,
    input  logic       pop,
    output pixel_t     rdata,
    output logic [1:0] count
);

    pixel_t     mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop && (count_q != 2'd0);
    // A push on a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/sprite_blit_reader.sv
// sprite_blit_reader: walks a row-major sprite in ROM and emits opaque,
// on-screen pixels toward the frame buffer.
//   Clk, Reset_n      : clock, synchronous active-low reset
//   start             : request (taken only in idle); latches the sprite inputs
//   base_addr         : ROM address of sprite pixel (0,0)
//   spr_w, spr_h      : sprite size; zero in either dimension finishes at once
//   pos_x, pos_y      : screen position of the sprite's top-left
//   flip              : horizontal mirror
//   busy, done        : busy while not idle; done is a one-cycle completion pulse
//   rom_addr/rom_data : ROM read port, data returns one cycle after the address
//   px_valid/px_ready : pixel handshake, px_x/px_y/px_color held while stalled
module sprite_blit_reader
    import sprite_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [9:0]         spr_w,
    input  logic [8:0]         spr_h,
    input  logic [9:0]         pos_x,
    input  logic [8:0]         pos_y,
    input  logic               flip,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [9:0]         px_x,
    output logic [8:0]         px_y,
    output logic [COLOR_W-1:0] px_color
);

    state_e state_q, state_d;

    // Latched sprite description
    logic [ADDR_W-1:0] base_q;
    logic [9:0]        w_q;
    logic [8:0]        h_q;
    logic [9:0]        x0_q;
    logic [8:0]        y0_q;
    logic              flip_q;

    // Walk position; row_base_q tracks row_q * w_q without a multiplier
    logic [9:0]        col_q;
    logic [8:0]        row_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [ADDR_W-1:0] rom_addr_q;

    // Side info travelling alongside the ROM read (valid == read in flight)
    logic       s_valid_q;
    logic       s_drop_q;
    logic [9:0] s_x_q;
    logic [8:0] s_y_q;

    logic              accept;
    logic              issue;
    logic              pop;
    logic              push;
    logic              last_col;
    logic              last_pix;
    logic [1:0]        fifo_count;
    logic [2:0]        occ;
    logic [9:0]        col_eff;
    logic [ADDR_W-1:0] addr_calc;
    logic [10:0]       x_full;
    logic [9:0]        y_full;
    logic              drop;
    pixel_t            push_pix;
    pixel_t            head;

    assign accept   = (state_q == StIdle) && start;
    assign pop      = px_valid && px_ready;
    // Entries the FIFO will hold after this edge, assuming the in-flight read is pushed
    assign occ      = 3'(fifo_count) + 3'(s_valid_q) - 3'(pop);
    assign last_col = (col_q == w_q - 10'd1);
    assign last_pix = last_col && (row_q == h_q - 9'd1);
    assign col_eff  = flip_q ? (w_q - 10'd1 - col_q) : col_q;
    assign addr_calc = base_q + row_base_q + ADDR_W'(col_eff);

    // One bit wider than the port so a wrap past 1023/511 is still seen as off-screen
    assign x_full = {1'b0, x0_q} + {1'b0, col_q};
    assign y_full = {1'b0, y0_q} + {1'b0, row_q};
    assign drop   = (x_full >= 11'(SCREEN_W)) || (y_full >= 10'(SCREEN_H));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = ((spr_w == 10'd0) || (spr_h == 9'd0)) ? StDone : StFetch;
                end
            end
            StFetch: begin
                if (issue && last_pix) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!s_valid_q && (fifo_count == 2'd0)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        issue    = (state_q == StFetch) && (occ < 3'd2);
        rom_addr = issue ? addr_calc : rom_addr_q;
    end

    // ---------------- Walk and ROM side-info pipeline ----------------
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            base_q     <= '0;
            w_q        <= '0;
            h_q        <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            flip_q     <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            rom_addr_q <= '0;
            s_valid_q  <= 1'b0;
            s_drop_q   <= 1'b0;
            s_x_q      <= '0;
            s_y_q      <= '0;
        end else begin
            if (accept) begin
                base_q     <= base_addr;
                w_q        <= spr_w;
                h_q        <= spr_h;
                x0_q       <= pos_x;
                y0_q       <= pos_y;
                flip_q     <= flip;
                col_q      <= '0;
                row_q      <= '0;
                row_base_q <= '0;
            end
            if (issue) begin
                rom_addr_q <= addr_calc;
                if (last_col) begin
                    col_q      <= '0;
                    row_q      <= row_q + 9'd1;
                    row_base_q <= row_base_q + ADDR_W'(w_q);
                end else begin
                    col_q <= col_q + 10'd1;
                end
                s_x_q    <= x_full[9:0];
                s_y_q    <= y_full[8:0];
                s_drop_q <= drop;
            end
            s_valid_q <= issue;
        end
    end

    // Transparent or clipped returns retire here without entering the FIFO
    assign push     = s_valid_q && !s_drop_q && (rom_data != TRANSPARENT);
    assign push_pix = '{x: s_x_q, y: s_y_q, color: rom_data};

    pix_fifo2 u_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push    (push),
        .wdata   (push_pix),
        .pop     (pop),
        .rdata   (head),
        .count   (fifo_count)
    );

    assign px_valid = (fifo_count != 2'd0);
    assign px_x     = head.x;
    assign px_y     = head.y;
    assign px_color = head.color;

endmodule

// File: tb/tb_sprite_blit_reader.sv
module tb_sprite_blit_reader;
    import sprite_pkg::*;

    logic               Clk = 1'b0;
    logic               Reset_n;
    logic               start;
    logic [ADDR_W-1:0]  base_addr;
    logic [9:0]         spr_w;
    logic [8:0]         spr_h;
    logic [9:0]         pos_x;
    logic [8:0]         pos_y;
    logic               flip;
    logic               busy;
    logic               done;
    logic [ADDR_W-1:0]  rom_addr;
    logic [COLOR_W-1:0] rom_data = '0;
    logic               px_valid;
    logic               px_ready;
    logic [9:0]         px_x;
    logic [8:0]         px_y;
    logic [COLOR_W-1:0] px_color;

    sprite_blit_reader dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .base_addr (base_addr),
        .spr_w     (spr_w),
        .spr_h     (spr_h),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .flip      (flip),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_color  (px_color)
    );

    always #5 Clk = ~Clk;

    // Registered ROM model, indexed by the low 10 address bits
    logic [COLOR_W-1:0] rom_mem [1024];
    always @(posedge Clk) rom_data <= rom_mem[rom_addr[9:0]];

    int     n_tests = 0;
    int     n_fail  = 0;
    pixel_t exp_q[$];
    int     addr_chk[$];

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: pops one expected pixel per accepted transfer and
    // checks that a stalled pixel stays put.
    initial begin
        logic   held_v;
        pixel_t held;
        pixel_t e;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check("px_valid_hold", int'(px_valid), 1);
                    if (px_valid) check("px_data_hold", int'({px_x, px_y, px_color}), int'(held));
                end
                if (px_valid && px_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL px_unexpected: got x=%0d y=%0d c=%0d, expected none",
                                 px_x, px_y, px_color);
                    end else begin
                        e = exp_q.pop_front();
                        check("px", int'({px_x, px_y, px_color}), int'(e));
                    end
                end
                held_v = px_valid && !px_ready;
                held   = '{x: px_x, y: px_y, color: px_color};
            end
        end
    end

    // Reference model straight from the walk rules: row-major, mirrored
    // column when flipped, drop transparent or off-screen pixels.
    task automatic build_model(input int b, input int w, input int h, input int x0,
                               input int y0, input int fl, input int chk);
        int a, cc, x, y;
        logic [COLOR_W-1:0] c;
        for (int r = 0; r < h; r++) begin
            for (int col = 0; col < w; col++) begin
                cc = (fl != 0) ? (w - 1 - col) : col;
                a  = (b + r * w + cc) % (1 << ADDR_W);
                c  = rom_mem[a % 1024];
                x  = x0 + col;
                y  = y0 + r;
                if (chk != 0) addr_chk.push_back(a);
                if (c != 0 && x < int'(SCREEN_W) && y < int'(SCREEN_H))
                    exp_q.push_back('{x: 10'(x), y: 9'(y), color: c});
            end
        end
    endtask

    task automatic scramble();
        base_addr = ADDR_W'($urandom);
        spr_w     = 10'($urandom_range(0, 3));
        spr_h     = 9'($urandom_range(0, 3));
        pos_x     = 10'($urandom);
        pos_y     = 9'($urandom);
        flip      = 1'($urandom);
    endtask

    task automatic fill_rom_random();
        for (int i = 0; i < 1024; i++)
            rom_mem[i] = ($urandom_range(0, 3) == 0) ? '0 : COLOR_W'($urandom_range(1, 31));
    endtask

    // rmode: 0 ready high, 1 random ready, 2 ready low for cycles lo..hi
    task automatic run_sprite(input int b, input int w, input int h, input int x0, input int y0,
                              input int fl, input int rmode, input int lo, input int hi,
                              input int chk);
        int   k;
        int   done_k;
        logic got;
        build_model(b, w, h, x0, y0, fl, chk);
        @(posedge Clk); #1;
        base_addr = ADDR_W'(b);
        spr_w     = 10'(w);
        spr_h     = 9'(h);
        pos_x     = 10'(x0);
        pos_y     = 9'(y0);
        flip      = 1'(fl);
        start     = 1'b1;
        px_ready  = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        scramble();
        got    = 1'b0;
        done_k = 0;
        k      = 1;
        while (!got && k <= 4000) begin
            case (rmode)
                0:       px_ready = 1'b1;
                1:       px_ready = ($urandom_range(0, 3) != 0);
                default: px_ready = !(k >= lo && k <= hi);
            endcase
            // A second start while busy must be ignored
            start = (k == 3 && w * h >= 4);
            @(negedge Clk);
            if (k == 1) check("busy_after_start", int'(busy), 1);
            if (k <= addr_chk.size()) check("rom_addr", int'(rom_addr), addr_chk[k-1]);
            if (done) begin
                got    = 1'b1;
                done_k = k;
            end else begin
                @(posedge Clk); #1;
                k++;
            end
        end
        check("done_seen", int'(got), 1);
        if (got) begin
            if (w == 0 || h == 0) check("zero_done_latency", done_k, 1);
            // start coinciding with done is ignored
            spr_w = 10'd0;
            spr_h = 9'd1;
            start = 1'b1;
            @(posedge Clk); #1;
            start    = 1'b0;
            px_ready = 1'b1;
            @(negedge Clk);
            check("idle_after_done_busy", int'(busy), 0);
            check("done_one_cycle", int'(done), 0);
        end
        check("pending_px", exp_q.size(), 0);
        exp_q.delete();
        addr_chk.delete();
    endtask

    task automatic reset_mid_run();
        int nd;
        fill_rom_random();
        build_model(600, 8, 8, 0, 0, 0, 0);
        @(posedge Clk); #1;
        base_addr = ADDR_W'(600);
        spr_w     = 10'd8;
        spr_h     = 9'd8;
        pos_x     = 10'd0;
        pos_y     = 9'd0;
        flip      = 1'b0;
        start     = 1'b1;
        px_ready  = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (5) @(posedge Clk);
        #1 Reset_n = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(negedge Clk);
        check("rst_busy", int'(busy), 0);
        check("rst_px_valid", int'(px_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        exp_q.delete();
        nd = 0;
        repeat (10) begin
            @(negedge Clk);
            if (done) nd++;
        end
        check("no_done_after_reset", nd, 0);
    endtask

    initial begin
        int w, h, x0, y0;
        Reset_n   = 1'b0;
        start     = 1'b0;
        px_ready  = 1'b1;
        base_addr = '0;
        spr_w     = '0;
        spr_h     = '0;
        pos_x     = '0;
        pos_y     = '0;
        flip      = 1'b0;
        for (int i = 0; i < 1024; i++) rom_mem[i] = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_px_valid", int'(px_valid), 0);
        check("reset_rom_addr", int'(rom_addr), 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        // Plain and mirrored 2x2 walk
        rom_mem[100] = 5'd1;
        rom_mem[101] = 5'd2;
        rom_mem[102] = 5'd3;
        rom_mem[103] = 5'd4;
        run_sprite(100, 2, 2, 10, 20, 0, 0, 0, 0, 1);
        run_sprite(100, 2, 2, 10, 20, 1, 0, 0, 0, 1);

        // Transparency
        rom_mem[200] = 5'd0;
        rom_mem[201] = 5'd7;
        rom_mem[202] = 5'd0;
        run_sprite(200, 3, 1, 50, 60, 0, 0, 0, 0, 1);

        // Backpressure: address stalls while two pixels are buffered
        rom_mem[300] = 5'd5;
        rom_mem[301] = 5'd6;
        rom_mem[302] = 5'd7;
        rom_mem[303] = 5'd8;
        addr_chk = '{300, 301, 301, 301, 301, 302, 303};
        run_sprite(300, 4, 1, 100, 100, 0, 2, 2, 5, 0);

        // Right-edge clipping and zero size
        for (int i = 400; i < 404; i++) rom_mem[i] = 5'd9;
        run_sprite(400, 4, 1, 638, 5, 0, 0, 0, 0, 1);
        run_sprite(500, 0, 3, 0, 0, 0, 0, 0, 0, 1);

        reset_mid_run();
        run_sprite(100, 2, 2, 10, 20, 0, 0, 0, 0, 1);

        // Randomized sprites, including edge positions and 10-bit wrap
        for (int n = 0; n < 30; n++) begin
            fill_rom_random();
            w = $urandom_range(0, 9);
            h = $urandom_range(0, 6);
            case ($urandom_range(0, 2))
                0:       begin x0 = $urandom_range(0, 639);   y0 = $urandom_range(0, 479); end
                1:       begin x0 = $urandom_range(630, 639); y0 = $urandom_range(474, 479); end
                default: begin x0 = $urandom_range(1016, 1023); y0 = $urandom_range(506, 511); end
            endcase
            if ($urandom_range(0, 1) == 0) begin
                run_sprite(int'($urandom_range(0, (1 << ADDR_W) - 1)), w, h, x0, y0,
                           int'($urandom_range(0, 1)), 0, 0, 0, 1);
            end else begin
                run_sprite(int'($urandom_range(0, (1 << ADDR_W) - 1)), w, h, x0, y0,
                           int'($urandom_range(0, 1)), 1, 0, 0, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
